// File: rtl/pdm_serializer.sv
// -----------------------------------------------------------------------------
// pdm_serializer
//
// Transmit-side PDM serializer. Accepts signed PCM samples over a valid/ready
// handshake and turns each one into OSR bits of a pulse-density stream. A
// first-order sigma-delta modulator does the conversion. The block also
// generates the PDM bit clock for an external amplifier or low-pass filter.
//
// Parameters
//   CLK_DIV   clock_i cycles per pdm_clk_o half-period
//   SAMPLE_W  PCM sample width (two's complement)
//   OSR       PDM bits emitted per PCM sample
//
// Ports
//   clock_i         system clock; all logic runs on its rising edge
//   reset_n_i       asynchronous active-low reset
//   enable_i        runs the modulator; low stops the bit clock and clears
//                   the divider, bit counter and accumulator
//   sample_i        PCM sample, signed
//   valid_i         sample_i is valid
//   ready_o         holding buffer is empty and can accept a sample
//   pdm_clk_o       PDM bit clock
//   pdm_data_o      PDM bit stream; changes on the pdm_clk_o falling edge
//   sample_taken_o  1-cycle pulse when the holding buffer moves into the
//                   active sample register
//   underrun_o      1-cycle pulse when a sample load finds the buffer empty
//
// Build option
//   PDM_SER_UNDERRUN_HOLD_EN  when defined, an underrun keeps the previous
//                             active sample, so the last sample repeats.
//                             When undefined, an underrun loads midscale
//                             (signed 0), which gives a 50% density (silence).
// -----------------------------------------------------------------------------
module pdm_serializer #(
  parameter int CLK_DIV  = 50,
  parameter int SAMPLE_W = 16,
  parameter int OSR      = 64
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  input  logic                enable_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic                pdm_clk_o,
  output logic                pdm_data_o,
  output logic                sample_taken_o,
  output logic                underrun_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(OSR - 1);
  localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  // XOR mask that flips the sign bit: two's complement -> offset binary.
  localparam logic [SAMPLE_W-1:0] MSB_MASK = {1'b1, {(SAMPLE_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]    div_q,          div_d;
  logic                pdm_clk_q,      pdm_clk_d;
  logic                pdm_data_q,     pdm_data_d;
  logic [CNT_W-1:0]    bit_cnt_q,      bit_cnt_d;
  logic [SAMPLE_W-1:0] acc_q,          acc_d;
  logic [SAMPLE_W-1:0] hold_q,         hold_d;
  logic                hold_full_q,    hold_full_d;
  logic [SAMPLE_W-1:0] active_q,       active_d;
  logic                first_q,        first_d;
  logic                sample_taken_q, sample_taken_d;
  logic                underrun_q,     underrun_d;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  logic                div_wrap;
  logic                bit_evt;
  logic                bit_wrap;
  logic                load_evt;
  logic                accept;
  logic [SAMPLE_W-1:0] u_val;
  logic [SAMPLE_W:0]   sum;

  assign div_wrap = (div_q == DIV_LAST);
  // A bit update happens on the edge where pdm_clk_o toggles 1->0.
  assign bit_evt  = enable_i && div_wrap && pdm_clk_q;
  assign bit_wrap = (bit_cnt_q == CNT_LAST);
  // The first bit update after enable also loads a sample, so the first
  // sample starts right away instead of after a full OSR window.
  assign load_evt = bit_evt && (bit_wrap || first_q);
  // A full buffer forces ready_o low. An accept and a load therefore never
  // act on a full buffer in the same cycle.
  assign accept   = valid_i && !hold_full_q;

  assign u_val    = active_q ^ MSB_MASK;
  assign sum      = {1'b0, acc_q} + {1'b0, u_val};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d gets a default first. A signal missed on any path here
    // would otherwise become a latch.
    div_d          = div_q;
    pdm_clk_d      = pdm_clk_q;
    pdm_data_d     = pdm_data_q;
    bit_cnt_d      = bit_cnt_q;
    acc_d          = acc_q;
    hold_d         = hold_q;
    hold_full_d    = hold_full_q;
    active_d       = active_q;
    first_d        = first_q;
    sample_taken_d = 1'b0;
    underrun_d     = 1'b0;

    if (!enable_i) begin
      // Halted: clear the modulator and rearm the first-load behaviour.
      // The holding buffer keeps running so that a sample can be preloaded.
      div_d      = '0;
      pdm_clk_d  = 1'b0;
      pdm_data_d = 1'b0;
      bit_cnt_d  = '0;
      acc_d      = '0;
      first_d    = 1'b1;
    end else begin
      if (div_wrap) begin
        div_d     = '0;
        pdm_clk_d = ~pdm_clk_q;
      end else begin
        div_d     = div_q + DIV_ONE;
      end

      if (bit_evt) begin
        // The carry out of the accumulator is the PDM bit.
        pdm_data_d = sum[SAMPLE_W];
        acc_d      = sum[SAMPLE_W-1:0];
        first_d    = 1'b0;
        bit_cnt_d  = load_evt ? '0 : (bit_cnt_q + CNT_ONE);
      end
    end

    if (accept) begin
      hold_d      = sample_i;
      hold_full_d = 1'b1;
    end

    // The sample loaded here first affects the next bit. The bit computed
    // on this same edge still uses the old active_q.
    if (load_evt) begin
      if (hold_full_q) begin
        active_d       = hold_q;
        hold_full_d    = 1'b0;
        sample_taken_d = 1'b1;
      end else begin
        underrun_d     = 1'b1;
`ifdef PDM_SER_UNDERRUN_HOLD_EN
        active_d       = active_q;
`else
        active_d       = '0;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge no matter the statement order.
  // The sample registers are reset along with the control state. After a
  // reset, the first load then sees a defined midscale rather than X.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      div_q          <= '0;
      pdm_clk_q      <= 1'b0;
      pdm_data_q     <= 1'b0;
      bit_cnt_q      <= '0;
      acc_q          <= '0;
      hold_q         <= '0;
      hold_full_q    <= 1'b0;
      active_q       <= '0;
      first_q        <= 1'b1;
      sample_taken_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      div_q          <= div_d;
      pdm_clk_q      <= pdm_clk_d;
      pdm_data_q     <= pdm_data_d;
      bit_cnt_q      <= bit_cnt_d;
      acc_q          <= acc_d;
      hold_q         <= hold_d;
      hold_full_q    <= hold_full_d;
      active_q       <= active_d;
      first_q        <= first_d;
      sample_taken_q <= sample_taken_d;
      underrun_q     <= underrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all driven straight from flops)
  // ---------------------------------------------------------------------------
  assign ready_o        = ~hold_full_q;
  assign pdm_clk_o      = pdm_clk_q;
  assign pdm_data_o     = pdm_data_q;
  assign sample_taken_o = sample_taken_q;
  assign underrun_o     = underrun_q;

endmodule
